// File: rtl/ps2_pkg.sv
// Shared PS/2 receiver definitions: state encoding, frame geometry, scan-code constants.
// Pure declarations; no timing or flow-control behaviour of its own.
package ps2_pkg;

  typedef enum logic [1:0] {
    RX_IDLE   = 2'd0,
    RX_DATA   = 2'd1,
    RX_PARITY = 2'd2,
    RX_STOP   = 2'd3
  } rx_state_e;

  localparam int         PS2_FRAME_BITS      = 11;
  localparam int         PS2_DATA_BITS       = PS2_FRAME_BITS - 3;
  localparam logic [7:0] PS2_BREAK           = 8'hF0;
  localparam logic [7:0] PS2_EXT             = 8'hE0;
  localparam int         PS2_TIMEOUT_DEFAULT = 50000;

  // Odd parity: data plus parity bit must hold an odd number of ones.
  function automatic logic odd_parity_ok(input logic [7:0] d, input logic p);
    return ^{d, p};
  endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 frame receiver: pin synchronizers, falling-edge detect, frame FSM, parity and idle timeout.
// byte_vld_o pulses one cycle in the cycle the stop-bit edge is detected; no backpressure input.
module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = PS2_TIMEOUT_DEFAULT
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic       byte_vld_o,
  output logic [7:0] byte_dat_o,
  output logic       frame_err_o
);

  localparam int             TW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0]  TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [2:0]     BIT_LAST = 3'(PS2_DATA_BITS - 1);

  logic          clk_s1_q, clk_s2_q, clk_prev_q, dat_s1_q, dat_s2_q;
  rx_state_e     state_q, state_d;
  logic [7:0]    shift_q, shift_d;
  logic [2:0]    bitcnt_q, bitcnt_d;
  logic          par_bad_q, par_bad_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          fall, timeout;

  // Synchronizers idle high so reset never fabricates a falling edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      clk_s1_q   <= 1'b1;
      clk_s2_q   <= 1'b1;
      clk_prev_q <= 1'b1;
      dat_s1_q   <= 1'b1;
      dat_s2_q   <= 1'b1;
    end else begin
      clk_s1_q   <= ps2_clk_i;
      clk_s2_q   <= clk_s1_q;
      clk_prev_q <= clk_s2_q;
      dat_s1_q   <= ps2_data_i;
      dat_s2_q   <= dat_s1_q;
    end
  end

  assign fall    = clk_prev_q & ~clk_s2_q;
  assign timeout = (state_q != RX_IDLE) && !fall && (tmo_q == TMO_LAST);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= RX_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (timeout) begin
      state_d = RX_IDLE;
    end else if (fall) begin
      case (state_q)
        RX_IDLE:   if (!dat_s2_q) state_d = RX_DATA;
        RX_DATA:   if (bitcnt_q == BIT_LAST) state_d = RX_PARITY;
        RX_PARITY: state_d = RX_STOP;
        RX_STOP:   state_d = RX_IDLE;
        default:   state_d = RX_IDLE;
      endcase
    end
  end

  always_comb begin
    byte_vld_o  = 1'b0;
    frame_err_o = timeout;
    if (fall) begin
      case (state_q)
        RX_IDLE: frame_err_o = dat_s2_q;
        RX_STOP: begin
          if (!par_bad_q && dat_s2_q) byte_vld_o  = 1'b1;
          else                        frame_err_o = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign byte_dat_o = shift_q;

  always_comb begin
    shift_d   = shift_q;
    bitcnt_d  = bitcnt_q;
    par_bad_d = par_bad_q;
    tmo_d     = (state_q == RX_IDLE || fall || timeout) ? '0 : tmo_q + 1'b1;
    if (timeout) begin
      shift_d  = '0;
      bitcnt_d = '0;
    end else if (fall) begin
      case (state_q)
        RX_IDLE: begin
          bitcnt_d  = '0;
          par_bad_d = 1'b0;
        end
        RX_DATA: begin
          shift_d  = {dat_s2_q, shift_q[7:1]};
          bitcnt_d = bitcnt_q + 1'b1;
        end
        RX_PARITY: par_bad_d = !odd_parity_ok(shift_q, dat_s2_q);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      shift_q   <= '0;
      bitcnt_q  <= '0;
      par_bad_q <= 1'b0;
      tmo_q     <= '0;
    end else begin
      shift_q   <= shift_d;
      bitcnt_q  <= bitcnt_d;
      par_bad_q <= par_bad_d;
      tmo_q     <= tmo_d;
    end
  end

endmodule

// File: rtl/ps2_scancode_fifo.sv
// PS/2 keyboard receiver feeding a first-word-fall-through byte FIFO; full FIFO drops and flags overflow.
// Byte visible one cycle after stop-bit detection; PS2_BREAK_FILTER_EN drops F0 break codes and their follower.
module ps2_scancode_fifo
  import ps2_pkg::*;
#(
  parameter int DEPTH          = 8,
  parameter int TIMEOUT_CYCLES = PS2_TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  input  logic        rd_en,
  input  logic        clr,
  output logic [15:0] rdata,
  output logic        empty,
  output logic        full,
  output logic [4:0]  count,
  output logic        overflow,
  output logic        frame_err
);

  localparam int         AW      = $clog2(DEPTH);
  localparam logic [4:0] DEPTH_C = 5'(DEPTH);

  logic          rx_vld, rx_err, accept, do_push, do_pop;
  logic [7:0]    rx_dat;
  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [4:0]    count_q;
  logic          ovf_q, ferr_q;

  ps2_frame_rx #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_rx (
    .clk_i       (clk),
    .rst_ni      (rst),
    .ps2_clk_i   (ps2_clk),
    .ps2_data_i  (ps2_data),
    .byte_vld_o  (rx_vld),
    .byte_dat_o  (rx_dat),
    .frame_err_o (rx_err)
  );

`ifdef PS2_BREAK_FILTER_EN
  // Break code F0 and the key byte following it are swallowed; E0 prefixes pass.
  logic skip_q, skip_d;

  always_comb begin
    skip_d = skip_q;
    accept = 1'b0;
    if (rx_vld) begin
      if (skip_q)                   skip_d = 1'b0;
      else if (rx_dat == PS2_BREAK) skip_d = 1'b1;
      else                          accept = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) skip_q <= 1'b0;
    else      skip_q <= skip_d;
  end
`else
  assign accept = rx_vld;
`endif

  assign empty    = (count_q == 5'd0);
  assign full     = (count_q == DEPTH_C);
  assign count    = count_q;
  assign overflow = ovf_q;
  assign frame_err = ferr_q;
  assign rdata    = empty ? 16'h0000 : {8'h00, mem_q[rptr_q]};
  assign do_push  = accept && !full;
  assign do_pop   = rd_en && !empty;

  always_ff @(posedge clk) begin
    if (do_push && !clr) mem_q[wptr_q] <= rx_dat;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      ferr_q  <= 1'b0;
    end else if (clr) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 5'd1;
        2'b01:   count_q <= count_q - 5'd1;
        default: ;
      endcase
      if (accept && full) ovf_q  <= 1'b1;
      if (rx_err)         ferr_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ps2_scancode_fifo.sv
// Randomized bench for ps2_scancode_fifo against a queue-based model of the received byte stream.
module tb_ps2_scancode_fifo;

  localparam int DEPTH = 8;
  localparam int TMO   = 120;
  localparam int HALF  = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ps2_clk = 1'b1;
  logic        ps2_data = 1'b1;
  logic        rd_en = 1'b0;
  logic        clr = 1'b0;
  logic [15:0] rdata;
  logic        empty, full, overflow, frame_err;
  logic [4:0]  count;

  always #5 clk = ~clk;

  ps2_scancode_fifo #(.DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
    .clk       (clk),
    .rst       (rst),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .rd_en     (rd_en),
    .clr       (clr),
    .rdata     (rdata),
    .empty     (empty),
    .full      (full),
    .count     (count),
    .overflow  (overflow),
    .frame_err (frame_err)
  );

  int        n_cmp = 0;
  int        n_bad = 0;
  logic [7:0] mq[$];
  bit        m_ovf = 0, m_ferr = 0, m_skip = 0;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag);
    logic [15:0] exp_rd;
    exp_rd = (mq.size() > 0) ? {8'h00, mq[0]} : 16'h0000;
    chk({tag, ".count"},     16'(count),     16'(mq.size()));
    chk({tag, ".empty"},     16'(empty),     16'(mq.size() == 0));
    chk({tag, ".full"},      16'(full),      16'(mq.size() == DEPTH));
    chk({tag, ".rdata"},     rdata,          exp_rd);
    chk({tag, ".overflow"},  16'(overflow),  16'(m_ovf));
    chk({tag, ".frame_err"}, 16'(frame_err), 16'(m_ferr));
  endtask

  // strobe: 0 none, 1 rd_en, 2 clr, applied in the cycle the byte lands.
  task automatic model_event(input bit good, input logic [7:0] b, input int strobe);
    bit acc;
    int sz;
    acc = good;
    sz  = mq.size();
`ifdef PS2_BREAK_FILTER_EN
    if (good) begin
      if (m_skip) begin m_skip = 0; acc = 0; end
      else if (b == 8'hF0) begin m_skip = 1; acc = 0; end
    end
`endif
    if (strobe == 2) begin
      mq.delete();
      m_ovf  = 0;
      m_ferr = 0;
      return;
    end
    if (!good) m_ferr = 1;
    if (strobe == 1 && sz > 0) void'(mq.pop_front());
    if (acc) begin
      if (sz == DEPTH) m_ovf = 1;
      else             mq.push_back(b);
    end
  endtask

  task automatic ps2_bit(input logic b);
    ps2_data = b;
    repeat (HALF) @(posedge clk);
    #1 ps2_clk = 1'b0;
    repeat (HALF) @(posedge clk);
    #1 ps2_clk = 1'b1;
  endtask

  // kind: 0 good, 1 bad parity, 2 bad stop bit.
  task automatic send_frame(input logic [7:0] b, input int kind, input int strobe);
    logic par;
    par = ~^b;
    if (kind == 1) par = ~par;
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit(par);
    ps2_data = (kind == 2) ? 1'b0 : 1'b1;
    repeat (HALF) @(posedge clk);
    #1 ps2_clk = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("latency.before", 16'(count), 16'(mq.size()));
    rd_en = (strobe == 1);
    clr   = (strobe == 2);
    @(posedge clk);
    #1;
    rd_en = 1'b0;
    clr   = 1'b0;
    model_event(kind == 0, b, strobe);
    check_state("frame");
    repeat (HALF - 3) @(posedge clk);
    #1 ps2_clk = 1'b1;
    ps2_data = 1'b1;
    repeat (HALF) @(posedge clk);
    #1;
  endtask

  task automatic pop(input string tag);
    chk({tag, ".head"}, rdata, (mq.size() > 0) ? {8'h00, mq[0]} : 16'h0000);
    rd_en = 1'b1;
    @(posedge clk);
    #1 rd_en = 1'b0;
    if (mq.size() > 0) void'(mq.pop_front());
    check_state(tag);
  endtask

  task automatic clr_pulse();
    clr = 1'b1;
    @(posedge clk);
    #1 clr = 1'b0;
    mq.delete();
    m_ovf  = 0;
    m_ferr = 0;
    check_state("clr");
  endtask

  initial begin
    #200000000;
    $display("FAIL watchdog: simulation did not complete, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b;
    int kind, strobe, np;

    #2 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_state("reset");
    rst = 1'b1;
    repeat (4) @(posedge clk);
    #1;

    send_frame(8'h1C, 0, 0);
    pop("pop1c");
    pop("pop_empty");

    send_frame(8'h1C, 1, 0);
    clr_pulse();
    send_frame(8'h33, 2, 0);
    ps2_bit(1'b1);
    repeat (HALF) @(posedge clk);
    #1;
    check_state("startbit_err");
    clr_pulse();

    for (int i = 1; i <= 9; i++) send_frame(8'(i), 0, 0);
    check_state("after_nine");
    for (int i = 0; i < 8; i++) pop("drain");

    for (int i = 0; i < DEPTH; i++) send_frame(8'($urandom), 0, 0);
    send_frame(8'hA5, 0, 1);
    send_frame(8'h6B, 0, 1);
    send_frame(8'h72, 0, 2);
    send_frame(8'h11, 0, 0);
    send_frame(8'h22, 0, 1);
    pop("mixed");

    ps2_bit(1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(1'($urandom));
    repeat (TMO - 20) @(posedge clk);
    #1;
    check_state("timeout.early");
    repeat (40) @(posedge clk);
    #1;
    m_ferr = 1;
    check_state("timeout");
    send_frame(8'h5A, 0, 0);
    pop("pop5a");
    clr_pulse();

    send_frame(8'h1C, 0, 0);
    send_frame(8'hF0, 0, 0);
    send_frame(8'h1C, 0, 0);
    send_frame(8'hE0, 0, 0);
    check_state("break_seq");
    clr_pulse();

    for (int n = 0; n < 40; n++) begin
      b = 8'($urandom);
      if ($urandom_range(0, 5) == 0) b = 8'hF0;
      kind   = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 2)) : 0;
      strobe = int'($urandom_range(0, 9));
      strobe = (strobe >= 9) ? 2 : (strobe >= 7) ? 1 : 0;
      send_frame(b, kind, strobe);
      np = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : 0;
      for (int k = 0; k < np; k++) pop("rand_pop");
      if ($urandom_range(0, 9) == 0) clr_pulse();
    end

    clr_pulse();
    send_frame(8'h15, 0, 0);
    send_frame(8'h24, 0, 0);
    ps2_bit(1'b0);
    for (int i = 0; i < 5; i++) ps2_bit(1'($urandom));
    rst = 1'b0;
    #1;
    mq.delete();
    m_ovf  = 0;
    m_ferr = 0;
    m_skip = 0;
    check_state("midframe_reset");
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    send_frame(8'h29, 0, 0);
    pop("pop29");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ps2_scancode_fifo.md
PS2_SCANCODE_FIFO -- requirements
Module: ps2_scancode_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning FIFO entries (power of 2, 2..16).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 50000, meaning idle clk cycles before a partial frame is abandoned.
REQ-003 SHALL have port clk  input  1  system clock; all state is on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port ps2_clk  input  1  raw PS/2 clock from the pin, asynchronous.
REQ-006 SHALL have port ps2_data  input  1  raw PS/2 data from the pin, asynchronous.
REQ-007 SHALL have port rd_en  input  1  pop the head byte this cycle.
REQ-008 SHALL have port clr  input  1  flush the FIFO and clear sticky flags; driven by the keyboard write-enable decode.
REQ-009 SHALL have port rdata  output  16  {8'h00, head byte}; 16'h0000 when empty.
REQ-010 SHALL have port empty  output  1  FIFO holds no bytes.
REQ-011 SHALL have port full  output  1  FIFO holds DEPTH bytes.
REQ-012 SHALL have port count  output  5  bytes held, 0..DEPTH.
REQ-013 SHALL have port overflow  output  1  sticky; a byte was dropped because the FIFO was full.
REQ-014 SHALL have port frame_err  output  1  sticky; parity, start, stop or timeout error seen.

Function
REQ-015 SHALL pass ps2_clk and ps2_data through 2-flop synchronizers and detect ps2_clk falling edges on the synchronized signal.
REQ-016 SHALL run receiver FSM IDLE -> DATA (8 bits, LSB first) -> PARITY -> STOP -> IDLE, advancing only on detected falling edges.
REQ-017 In IDLE, SHALL go to DATA on a falling edge with data=0; data=1 SHALL set frame_err and stay in IDLE.
REQ-018 In PARITY, SHALL check odd parity over 8 data bits plus parity bit; a mismatch SHALL flag the frame bad.
REQ-019 In STOP, SHALL push the byte only if parity was good and stop bit=1; otherwise SHALL set frame_err; both cases SHALL return to IDLE.
REQ-020 SHALL make a pushed byte visible (empty=0, rdata valid) on the cycle after the stop-bit edge is detected.
REQ-021 Outside IDLE, SHALL count clk cycles since the last edge; reaching TIMEOUT_CYCLES SHALL return to IDLE, discard the partial byte and set frame_err.
REQ-022 FIFO SHALL be first-word-fall-through: rdata shows the head combinationally from registered storage, and rd_en pops at the clock edge.
REQ-023 rd_en while empty SHALL be ignored with no flag change.
REQ-024 A push while full SHALL drop the byte and set overflow; a simultaneous rd_en SHALL be honoured.
REQ-025 Push and pop in the same cycle while not empty SHALL leave count unchanged and keep byte order.
REQ-026 Read and write pointers SHALL wrap modulo DEPTH; count SHALL never exceed DEPTH.
REQ-027 clr SHALL empty the FIFO and clear overflow and frame_err on the next edge, SHALL take priority over a simultaneous push or pop, and SHALL NOT disturb a frame in progress.

Reset
REQ-028 rst low SHALL immediately force FSM=IDLE, bit counter=0, timeout=0, pointers=0, count=0, empty=1, full=0, overflow=0, frame_err=0, rdata=16'h0000, and synchronizer flops=1 (idle bus).
REQ-029 Reset asserted mid-frame SHALL discard the partial frame; after release, reception SHALL resume at the next start bit.

Configuration
REQ-030 With PS2_BREAK_FILTER_EN defined, SHALL drop byte 8'hF0 and the single byte after it (break codes), so only make codes are queued; an 8'hE0 prefix SHALL pass through.
REQ-031 Without PS2_BREAK_FILTER_EN, SHALL queue every valid byte, including 8'hF0.

Structure
REQ-032 Shared package ps2_pkg SHALL hold the receiver state encoding, frame length (11), the F0/E0 constants and the default TIMEOUT_CYCLES.
REQ-033 The receiver (synchronizer, FSM, parity, timeout) SHALL be sub-module ps2_frame_rx with a 1-cycle byte_valid/byte output; the FIFO and filter SHALL stay in the top.

Verification
REQ-034 Frame 8'h1C with correct odd parity -> one cycle after stop: empty=0, rdata=16'h001C, count=1; rd_en pulse -> empty=1, rdata=16'h0000.
REQ-035 Frame 8'h1C with wrong parity -> frame_err=1, count=0; clr pulse -> frame_err=0.
REQ-036 Nine frames 8'h01..8'h09 with DEPTH=8 and no reads -> full=1, count=8, overflow=1; eight pops -> 8'h01..8'h08 in order.
REQ-037 Send start plus 4 data bits, then hold ps2_clk high for TIMEOUT_CYCLES -> frame_err=1, FSM in IDLE; next full frame 8'h5A -> rdata=16'h005A.
REQ-038 Bytes 8'h1C, 8'hF0, 8'h1C -> with PS2_BREAK_FILTER_EN count=1 (8'h1C); without it count=3 (1C, F0, 1C).
REQ-039 rst pulled low after bit 5 of a frame with 2 bytes queued -> count=0, empty=1 at once; next frame 8'h29 received correctly.
